dwc_generic: RTL and testbench

//  Parametrised streaming data-width converter for activation streams between FINN layers of differing fold.

---
 rtl/dwc_generic.sv | 178 +++++++++++++++++
 tb/tb_dwc_generic.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dwc_generic.sv
// Streaming data-width converter between FINN layers: packs narrow activation words into wide ones,
// slices wide words into narrow ones, or registers them straight through, flagging each frame's last beat.
module dwc_generic #(
    parameter int IN_WIDTH         = 8,
    parameter int OUT_WIDTH        = 32,
    parameter int ACTIVATION_WIDTH = 8,
    parameter int FRAME_ELEMS      = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  s_axis_input_tdata,
    input  logic                 s_axis_input_tvalid,
    output logic                 s_axis_input_tready,
    output logic [OUT_WIDTH-1:0] m_axis_output_tdata,
    output logic                 m_axis_output_tvalid,
    input  logic                 m_axis_output_tready,
    output logic                 m_axis_output_tlast
);

    localparam int IN_FOLD  = IN_WIDTH / ACTIVATION_WIDTH;
    localparam int OUT_FOLD = OUT_WIDTH / ACTIVATION_WIDTH;
    localparam int CNT_W    = $clog2(FRAME_ELEMS + 1);
    localparam bit UPSIZE   = OUT_WIDTH > IN_WIDTH;
    localparam bit DOWNSIZE = IN_WIDTH > OUT_WIDTH;

    if ((IN_WIDTH % OUT_WIDTH != 0) && (OUT_WIDTH % IN_WIDTH != 0)) begin : g_err_ratio
        $error("dwc_generic: IN_WIDTH and OUT_WIDTH must divide one another");
    end
    if (!DOWNSIZE && (FRAME_ELEMS % IN_FOLD != 0)) begin : g_err_in_fold
        $error("dwc_generic: FRAME_ELEMS must be a multiple of IN_FOLD");
    end
    if (DOWNSIZE && (FRAME_ELEMS % OUT_FOLD != 0)) begin : g_err_out_fold
        $error("dwc_generic: FRAME_ELEMS must be a multiple of OUT_FOLD");
    end

    if (UPSIZE) begin : g_up
        localparam int R     = OUT_WIDTH / IN_WIDTH;
        localparam int SEL_W = (R > 1) ? $clog2(R) : 1;

        logic [OUT_WIDTH-1:0] asm_q;
        logic [OUT_WIDTH-1:0] word_next;
        logic [OUT_WIDTH-1:0] out_data;
        logic [SEL_W-1:0]     slot_cnt;
        logic [CNT_W-1:0]     elem_cnt;
        logic                 out_vld;
        logic                 out_last;
        logic                 in_last;
        logic                 completes;
        logic                 in_fire;

        assign in_last   = (elem_cnt + CNT_W'(IN_FOLD)) == CNT_W'(FRAME_ELEMS);
        assign completes = (slot_cnt == SEL_W'(R - 1)) || in_last;
        // A completing beat needs the output register free or draining this cycle.
        assign s_axis_input_tready = !completes || !out_vld || m_axis_output_tready;
        assign in_fire   = s_axis_input_tvalid && s_axis_input_tready;

        // Completed word: filled slots, the current beat, zeros above it.
        always_comb begin
            word_next = '0;
            for (int i = 0; i < R; i++) begin
                if (SEL_W'(i) < slot_cnt) begin
                    word_next[i*IN_WIDTH +: IN_WIDTH] = asm_q[i*IN_WIDTH +: IN_WIDTH];
                end else if (SEL_W'(i) == slot_cnt) begin
                    word_next[i*IN_WIDTH +: IN_WIDTH] = s_axis_input_tdata;
                end
            end
        end

        always_ff @(posedge ap_clk) begin
            if (in_fire) begin
                asm_q[slot_cnt*IN_WIDTH +: IN_WIDTH] <= s_axis_input_tdata;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                slot_cnt <= '0;
                elem_cnt <= '0;
                out_vld  <= 1'b0;
                out_last <= 1'b0;
                out_data <= '0;
            end else begin
                if (in_fire) begin
                    slot_cnt <= completes ? '0 : slot_cnt + SEL_W'(1);
                    elem_cnt <= in_last ? '0 : elem_cnt + CNT_W'(IN_FOLD);
                end
                if (in_fire && completes) begin
                    out_data <= word_next;
                    out_last <= in_last;
                    out_vld  <= 1'b1;
                end else if (m_axis_output_tready) begin
                    out_vld  <= 1'b0;
                end
            end
        end

        assign m_axis_output_tdata  = out_data;
        assign m_axis_output_tvalid = out_vld;
        assign m_axis_output_tlast  = out_last;

    end else if (DOWNSIZE) begin : g_down
        localparam int R     = IN_WIDTH / OUT_WIDTH;
        localparam int SEL_W = (R > 1) ? $clog2(R) : 1;

        logic [IN_WIDTH-1:0] hold_q;
        logic [SEL_W-1:0]    slice_cnt;
        logic [CNT_W-1:0]    elem_cnt;
        logic                loaded;
        logic                out_last_elem;
        logic                retire;
        logic                out_fire;
        logic                in_fire;

        assign out_last_elem = (elem_cnt + CNT_W'(OUT_FOLD)) == CNT_W'(FRAME_ELEMS);
        // Slices past the frame's last element are dropped by retiring the word early.
        assign retire   = (slice_cnt == SEL_W'(R - 1)) || out_last_elem;
        assign out_fire = loaded && m_axis_output_tready;
        assign s_axis_input_tready = !loaded || (m_axis_output_tready && retire);
        assign in_fire  = s_axis_input_tvalid && s_axis_input_tready;

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                hold_q    <= '0;
                slice_cnt <= '0;
                elem_cnt  <= '0;
                loaded    <= 1'b0;
            end else begin
                if (out_fire) begin
                    slice_cnt <= retire ? '0 : slice_cnt + SEL_W'(1);
                    elem_cnt  <= out_last_elem ? '0 : elem_cnt + CNT_W'(OUT_FOLD);
                end
                if (in_fire) begin
                    hold_q <= s_axis_input_tdata;
                    loaded <= 1'b1;
                end else if (out_fire && retire) begin
                    loaded <= 1'b0;
                end
            end
        end

        assign m_axis_output_tdata  = hold_q[slice_cnt*OUT_WIDTH +: OUT_WIDTH];
        assign m_axis_output_tvalid = loaded;
        assign m_axis_output_tlast  = loaded && out_last_elem;

    end else begin : g_pass
        logic [OUT_WIDTH-1:0] out_data;
        logic [CNT_W-1:0]     elem_cnt;
        logic                 out_vld;
        logic                 out_last;
        logic                 in_last;
        logic                 in_fire;

        assign in_last = (elem_cnt + CNT_W'(IN_FOLD)) == CNT_W'(FRAME_ELEMS);
        assign s_axis_input_tready = !out_vld || m_axis_output_tready;
        assign in_fire = s_axis_input_tvalid && s_axis_input_tready;

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                elem_cnt <= '0;
                out_vld  <= 1'b0;
                out_last <= 1'b0;
                out_data <= '0;
            end else if (in_fire) begin
                elem_cnt <= in_last ? '0 : elem_cnt + CNT_W'(IN_FOLD);
                out_data <= s_axis_input_tdata;
                out_last <= in_last;
                out_vld  <= 1'b1;
            end else if (m_axis_output_tready) begin
                out_vld  <= 1'b0;
            end
        end

        assign m_axis_output_tdata  = out_data;
        assign m_axis_output_tvalid = out_vld;
        assign m_axis_output_tlast  = out_last;
    end

endmodule

// File: tb/tb_dwc_generic.sv
// Bench for dwc_generic: several width/frame configurations run side by side, each checked
// against a frame-level reference model (elements regrouped into output words).
module tb_dwc_generic;

    localparam int NCFG      = 7;
    localparam int NFR_RAND  = 1000;
    localparam int CYC_LIMIT = 80000;

    function automatic int cfg_iw(input int i);
        case (i)
            0: return 8;   1: return 32;  2: return 16;  3: return 8;
            4: return 16;  5: return 32;  default: return 16;
        endcase
    endfunction

    function automatic int cfg_ow(input int i);
        case (i)
            0: return 32;  1: return 8;   2: return 16;  3: return 16;
            4: return 8;   5: return 16;  default: return 32;
        endcase
    endfunction

    function automatic int cfg_fe(input int i);
        case (i)
            0: return 10;  1: return 6;   2: return 4;   3: return 5;
            4: return 5;   5: return 6;   default: return 6;
        endcase
    endfunction

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int n_done = 0;

    task automatic chk(input int cfg, input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", cfg, tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int IW   = cfg_iw(g);
        localparam int OW   = cfg_ow(g);
        localparam int FE   = cfg_fe(g);
        localparam int INF  = IW / 8;
        localparam int OUTF = OW / 8;
        localparam int NIN  = (FE + INF - 1) / INF;
        localparam int NOUT = (FE + OUTF - 1) / OUTF;
        localparam int NPRE = (OW > IW) ? (OW / IW - 1) : 1;

        logic          rst     = 1'b1;
        logic [IW-1:0] s_data  = '0;
        logic          s_valid = 1'b0;
        logic          s_ready;
        logic [OW-1:0] m_data;
        logic          m_valid;
        logic          m_ready = 1'b0;
        logic          m_last;

        logic [IW-1:0] in_q  [$];
        logic [OW:0]   exp_q [$];

        dwc_generic #(
            .IN_WIDTH        (IW),
            .OUT_WIDTH       (OW),
            .ACTIVATION_WIDTH(8),
            .FRAME_ELEMS     (FE)
        ) u_dut (
            .ap_clk              (ap_clk),
            .ap_rst              (rst),
            .s_axis_input_tdata  (s_data),
            .s_axis_input_tvalid (s_valid),
            .s_axis_input_tready (s_ready),
            .m_axis_output_tdata (m_data),
            .m_axis_output_tvalid(m_valid),
            .m_axis_output_tready(m_ready),
            .m_axis_output_tlast (m_last)
        );

        // One frame: FE elements; input words carry junk past the frame end, output words are zero-padded.
        task automatic add_frame(input bit rnd, input int base);
            logic [7:0]    el [FE];
            logic [IW-1:0] wi;
            logic [OW-1:0] wo;
            for (int k = 0; k < FE; k++) el[k] = rnd ? 8'($urandom) : 8'(base + k);
            for (int w = 0; w < NIN; w++) begin
                wi = '0;
                for (int j = 0; j < INF; j++) begin
                    if (w * INF + j < FE) wi[j*8 +: 8] = el[w*INF + j];
                    else                  wi[j*8 +: 8] = 8'($urandom);
                end
                in_q.push_back(wi);
            end
            for (int o = 0; o < NOUT; o++) begin
                wo = '0;
                for (int j = 0; j < OUTF; j++) begin
                    if (o * OUTF + j < FE) wo[j*8 +: 8] = el[o*OUTF + j];
                end
                exp_q.push_back({1'(o == NOUT - 1), wo});
            end
        endtask

        initial begin : run
            int          ip, oc, cyc, t_first, n1_in, n1_out, n_exp;
            bit          full, in_fire, out_fire, stall_prev;
            logic [OW-1:0] prev_d;
            logic        prev_l;
            logic [OW:0] e;

            add_frame(1'b0, 8'h11);
            add_frame(1'b0, 8'h01);
            for (int f = 0; f < NFR_RAND + 1; f++) add_frame(1'b1, 0);
            n_exp = exp_q.size();

            // Reset state
            repeat (2) @(posedge ap_clk);
            @(negedge ap_clk);
            chk(g, "rst_tvalid", 64'(m_valid), 64'(0));
            chk(g, "rst_tlast",  64'(m_last),  64'(0));
            chk(g, "rst_tdata",  64'(m_data),  64'(0));
            chk(g, "rst_tready", 64'(s_ready), 64'(1));
            @(posedge ap_clk); #1;
            rst = 1'b0;

            // Partial frame, then a reset pulse that must discard it
            for (int k = 0; k < NPRE; k++) begin
                s_valid = 1'b1;
                for (int j = 0; j < INF; j++) s_data[j*8 +: 8] = 8'(k * INF + j + 1);
                @(negedge ap_clk);
                chk(g, "pre_tready", 64'(s_ready), 64'(1));
                @(posedge ap_clk); #1;
            end
            s_valid = 1'b0;
            s_data  = '0;
            rst     = 1'b1;
            @(posedge ap_clk); #1;
            rst = 1'b0;
            @(negedge ap_clk);
            chk(g, "midrst_tvalid", 64'(m_valid), 64'(0));
            chk(g, "midrst_tlast",  64'(m_last),  64'(0));
            chk(g, "midrst_tready", 64'(s_ready), 64'(1));

            // Three frames at full rate, then random valid/ready for the rest
            full = 1'b1;
            n1_in = 3 * NIN;
            n1_out = 3 * NOUT;
            ip = 0; oc = 0; cyc = 0; t_first = -1;
            in_fire = 1'b0; stall_prev = 1'b0;
            prev_d = '0; prev_l = 1'b0;
            while (oc < n_exp && cyc < CYC_LIMIT) begin
                @(posedge ap_clk); #1;
                cyc++;
                if (in_fire) ip++;
                if (!s_valid || in_fire) begin
                    if (ip < (full ? n1_in : in_q.size()))
                        s_valid = full ? 1'b1 : 1'($urandom_range(0, 1));
                    else
                        s_valid = 1'b0;
                    s_data = s_valid ? in_q[ip] : '0;
                end
                m_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
                @(negedge ap_clk);
                if (stall_prev) begin
                    chk(g, "stall_tvalid", 64'(m_valid), 64'(1));
                    chk(g, "stall_tdata",  64'(m_data),  64'(prev_d));
                    chk(g, "stall_tlast",  64'(m_last),  64'(prev_l));
                end
                in_fire  = s_valid && s_ready;
                out_fire = m_valid && m_ready;
                if (in_fire && t_first < 0) t_first = cyc;
                if (out_fire) begin
                    e = exp_q[oc];
                    chk(g, "tdata", 64'(m_data), 64'(e[OW-1:0]));
                    chk(g, "tlast", 64'(m_last), 64'(e[OW]));
                    oc++;
                    if (full && oc == n1_out) begin
                        chk(g, "full_rate_cycles", 64'(cyc - t_first),
                            64'((n1_in > n1_out) ? n1_in : n1_out));
                        full = 1'b0;
                    end
                end
                stall_prev = m_valid && !m_ready;
                prev_d = m_data;
                prev_l = m_last;
            end
            if (oc < n_exp) chk(g, "timeout_beats", 64'(oc), 64'(n_exp));
            s_valid = 1'b0;
            m_ready = 1'b0;
            n_done++;
        end
    end

    initial begin
        for (int t = 0; t < 95000 && n_done < NCFG; t++) @(posedge ap_clk);
        if (n_done != NCFG) chk(-1, "configs_done", 64'(n_done), 64'(NCFG));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
